instr_encoder: RTL and testbench

Instruction encoder and program loader for the MIPS core's instruction memory. Accepts a stream of mnemonic-plus-field commands over a valid/ready handshake, packs each into a 32-bit MIPS word (R/I/J format) exactly as the control path decodes it, and writes the words into instruction memory at sequential word addresses. It sits between the test/boot command source and the imem write port.

---
 rtl/instr_encoder.sv | 159 +++++++++++++++
 tb/tb_instr_encoder.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Packs mnemonic-plus-field commands into 32-bit MIPS words and writes them to imem at sequential addresses.
// Build option ENC_FIELD_CHECK_EN: reject commands whose unused fields are nonzero instead of masking them.
module instr_encoder #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned BASE   = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_mn,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [25:0]       in_imm,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  CAP    = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FULL = 2'd2
    } state_t;

    state_t      state;
    logic        fmt_r, fmt_i, fmt_j, mn_ok, cmd_ok;
    logic        is_shift, is_jr;
    logic [5:0]  code6;
    logic [31:0] enc_word;
    logic        accept, wr_done, last_slot;

    // Mnemonic decode: format, funct/opcode.
    always_comb begin
        fmt_r = 1'b0;
        fmt_i = 1'b0;
        fmt_j = 1'b0;
        mn_ok = 1'b1;
        code6 = 6'b0;
        case (in_mn)
            5'd0:    begin fmt_r = 1'b1; code6 = 6'b100000; end
            5'd1:    begin fmt_r = 1'b1; code6 = 6'b100010; end
            5'd2:    begin fmt_r = 1'b1; code6 = 6'b100100; end
            5'd3:    begin fmt_r = 1'b1; code6 = 6'b100101; end
            5'd4:    begin fmt_r = 1'b1; code6 = 6'b100110; end
            5'd5:    begin fmt_r = 1'b1; code6 = 6'b000000; end
            5'd6:    begin fmt_r = 1'b1; code6 = 6'b000010; end
            5'd7:    begin fmt_r = 1'b1; code6 = 6'b001000; end
            5'd8:    begin fmt_i = 1'b1; code6 = 6'b001000; end
            5'd9:    begin fmt_i = 1'b1; code6 = 6'b001100; end
            5'd10:   begin fmt_i = 1'b1; code6 = 6'b001101; end
            5'd11:   begin fmt_i = 1'b1; code6 = 6'b001110; end
            5'd12:   begin fmt_i = 1'b1; code6 = 6'b100011; end
            5'd13:   begin fmt_i = 1'b1; code6 = 6'b101011; end
            5'd14:   begin fmt_i = 1'b1; code6 = 6'b000100; end
            5'd15:   begin fmt_i = 1'b1; code6 = 6'b000101; end
            5'd16:   begin fmt_j = 1'b1; code6 = 6'b000010; end
            5'd17:   begin fmt_j = 1'b1; code6 = 6'b000011; end
            default: mn_ok = 1'b0;
        endcase
    end

    assign is_shift = (in_mn == 5'd5) || (in_mn == 5'd6);
    assign is_jr    = (in_mn == 5'd7);

    // Word assembly; fields a format does not use are forced to zero.
    always_comb begin
        enc_word = 32'b0;
        if (fmt_r) begin
            enc_word = {6'b0,
                        is_shift ? 5'b0 : in_rs,
                        is_jr    ? 5'b0 : in_rt,
                        is_jr    ? 5'b0 : in_rd,
                        is_shift ? in_shamt : 5'b0,
                        code6};
        end else if (fmt_i) begin
            enc_word = {code6, in_rs, in_rt, in_imm[15:0]};
        end else if (fmt_j) begin
            enc_word = {code6, in_imm};
        end
    end

`ifdef ENC_FIELD_CHECK_EN
    logic field_bad;

    // Any nonzero field outside the format's used set makes the command illegal.
    always_comb begin
        field_bad = 1'b0;
        if (fmt_r) begin
            field_bad = (is_shift ? (in_rs != 5'b0) : (in_shamt != 5'b0))
                     || (is_jr && ((in_rt | in_rd) != 5'b0));
        end else if (fmt_i) begin
            field_bad = ((in_rd | in_shamt) != 5'b0) || (in_imm[25:16] != 10'b0);
        end else if (fmt_j) begin
            field_bad = ((in_rs | in_rt | in_rd | in_shamt) != 5'b0);
        end
    end

    assign cmd_ok = mn_ok && !field_bad;
`else
    assign cmd_ok = mn_ok;
`endif

    // Stop accepting once every remaining slot is already committed to the buffer.
    assign last_slot = ((count + CNT_W'(mem_we)) == CAP);
    assign in_ready  = (state == S_RUN) && (!mem_we || mem_ready) && !last_slot
                    && !start && !reset;
    assign accept    = in_valid && in_ready;
    assign wr_done   = mem_we && mem_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            mem_we    <= 1'b0;
            mem_addr  <= BASE_A;
            mem_wdata <= 32'b0;
            count     <= '0;
            full      <= 1'b0;
            err       <= 1'b0;
        end else if (start) begin
            state    <= S_RUN;
            mem_we   <= 1'b0;
            mem_addr <= BASE_A;
            count    <= '0;
            full     <= 1'b0;
            err      <= 1'b0;
        end else begin
            if (wr_done) begin
                count    <= count + CNT_W'(1);
                mem_addr <= mem_addr + ADDR_W'(1);
                if (count == CAP - CNT_W'(1)) begin
                    state <= S_FULL;
                    full  <= 1'b1;
                end
            end
            if (accept && cmd_ok) begin
                mem_we    <= 1'b1;
                mem_wdata <= enc_word;
            end else if (wr_done) begin
                mem_we <= 1'b0;
            end
            if (accept && !cmd_ok) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: reference encoder feeds a write scoreboard; a second
// instance with a 4-word memory covers address wrap and the FULL state.
module tb_instr_encoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, in_valid, mem_ready;
    logic [4:0]  in_mn, in_rs, in_rt, in_rd, in_shamt;
    logic [25:0] in_imm;

    logic        a_in_ready, a_mem_we, a_full, a_err;
    logic [7:0]  a_mem_addr;
    logic [31:0] a_mem_wdata;
    logic [8:0]  a_count;

    logic        b_in_ready, b_mem_we, b_full, b_err;
    logic [1:0]  b_mem_addr;
    logic [31:0] b_mem_wdata;
    logic [2:0]  b_count;

`ifdef ENC_FIELD_CHECK_EN
    localparam bit FIELD_CHECK = 1'b1;
`else
    localparam bit FIELD_CHECK = 1'b0;
`endif

    instr_encoder #(.ADDR_W(8), .BASE(0)) u_a (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_mn(in_mn), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .in_imm(in_imm), .mem_we(a_mem_we), .mem_ready(mem_ready), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .count(a_count), .full(a_full), .err(a_err)
    );

    instr_encoder #(.ADDR_W(2), .BASE(2)) u_b (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_mn(in_mn), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .in_imm(in_imm), .mem_we(b_mem_we), .mem_ready(mem_ready), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .count(b_count), .full(b_full), .err(b_err)
    );

    // Observed instance selected by use_b.
    bit          use_b;
    logic        s_in_ready, s_mem_we, s_full, s_err;
    logic [7:0]  s_mem_addr;
    logic [31:0] s_mem_wdata;
    logic [8:0]  s_count;
    assign s_in_ready  = use_b ? b_in_ready : a_in_ready;
    assign s_mem_we    = use_b ? b_mem_we : a_mem_we;
    assign s_full      = use_b ? b_full : a_full;
    assign s_err       = use_b ? b_err : a_err;
    assign s_mem_addr  = use_b ? {6'b0, b_mem_addr} : a_mem_addr;
    assign s_mem_wdata = use_b ? b_mem_wdata : a_mem_wdata;
    assign s_count     = use_b ? {6'b0, b_count} : a_count;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_cyc   = 0;
    int          pushed  = 0;
    bit          exp_err = 1'b0;
    logic [39:0] sb_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference encoder built from the opcode/funct tables.
    function automatic void ref_enc(input logic [4:0] mn, rs, rt, rd, sh, input logic [25:0] imm,
                                    output logic [31:0] w, output bit ok);
        logic bad;
        logic [5:0] op;
        ok  = 1'b1;
        bad = 1'b0;
        w   = 32'h0;
        op  = 6'h0;
        case (mn)
            5'd0, 5'd1, 5'd2, 5'd3, 5'd4: begin
                case (mn)
                    5'd0: op = 6'h20;
                    5'd1: op = 6'h22;
                    5'd2: op = 6'h24;
                    5'd3: op = 6'h25;
                    default: op = 6'h26;
                endcase
                w   = {6'h00, rs, rt, rd, 5'd0, op};
                bad = (sh != 5'd0);
            end
            5'd5, 5'd6: begin
                w   = {6'h00, 5'd0, rt, rd, sh, (mn == 5'd5) ? 6'h00 : 6'h02};
                bad = (rs != 5'd0);
            end
            5'd7: begin
                w   = {6'h00, rs, 15'd0, 6'h08};
                bad = (rt != 5'd0) || (rd != 5'd0) || (sh != 5'd0);
            end
            5'd8, 5'd9, 5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15: begin
                case (mn)
                    5'd8:  op = 6'h08;
                    5'd9:  op = 6'h0C;
                    5'd10: op = 6'h0D;
                    5'd11: op = 6'h0E;
                    5'd12: op = 6'h23;
                    5'd13: op = 6'h2B;
                    5'd14: op = 6'h04;
                    default: op = 6'h05;
                endcase
                w   = {op, rs, rt, imm[15:0]};
                bad = (rd != 5'd0) || (sh != 5'd0) || (imm[25:16] != 10'd0);
            end
            5'd16, 5'd17: begin
                w   = {(mn == 5'd16) ? 6'h02 : 6'h03, imm};
                bad = (rs != 5'd0) || (rt != 5'd0) || (rd != 5'd0) || (sh != 5'd0);
            end
            default: ok = 1'b0;
        endcase
        if (FIELD_CHECK && bad) ok = 1'b0;
    endfunction

    // One clock: sample handshakes at negedge, update scoreboard, return #1 after posedge.
    task automatic cyc(output bit acc);
        logic [31:0] w;
        logic [39:0] e;
        bit ok;
        int base, cap;
        base = use_b ? 2 : 0;
        cap  = use_b ? 4 : 256;
        @(negedge clk);
        acc = in_valid && s_in_ready;
        if (s_mem_we && mem_ready) begin
            chk("write_expected", 64'(sb_q.size() != 0), 64'(1));
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("wr_addr", 64'(s_mem_addr), 64'(e[39:32]));
                chk("wr_data", 64'(s_mem_wdata), 64'(e[31:0]));
            end
        end
        if (acc) begin
            ref_enc(in_mn, in_rs, in_rt, in_rd, in_shamt, in_imm, w, ok);
            if (ok) begin
                sb_q.push_back({8'((base + pushed) % cap), w});
                pushed++;
            end else begin
                exp_err = 1'b1;
            end
        end
        n_cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input logic [4:0] mn, rs, rt, rd, sh, input logic [25:0] imm);
        in_mn = mn; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh; in_imm = imm;
    endtask

    task automatic send(input logic [4:0] mn, rs, rt, rd, sh, input logic [25:0] imm,
                        input int budget, output bit acc);
        bit a;
        set_cmd(mn, rs, rt, rd, sh, imm);
        in_valid = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < budget && !acc; i++) begin
            cyc(a);
            acc = a;
        end
        in_valid = 1'b0;
    endtask

    task automatic send_ok(input string tag, input logic [4:0] mn, rs, rt, rd, sh,
                           input logic [25:0] imm);
        bit acc;
        send(mn, rs, rt, rd, sh, imm, 8, acc);
        chk(tag, 64'(acc), 64'(1));
    endtask

    task automatic clear_sb();
        sb_q.delete();
        pushed  = 0;
        exp_err = 1'b0;
    endtask

    task automatic do_start();
        bit a;
        start = 1'b1;
        cyc(a);
        start = 1'b0;
        clear_sb();
    endtask

    task automatic drain();
        bit a;
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) cyc(a);
        chk("drain", 64'(sb_q.size()), 64'(0));
    endtask

    task automatic check_rst(input string tag);
        chk({tag, "_in_ready"}, 64'(s_in_ready), 64'(0));
        chk({tag, "_mem_we"}, 64'(s_mem_we), 64'(0));
        chk({tag, "_mem_addr"}, 64'(s_mem_addr), 64'(use_b ? 2 : 0));
        chk({tag, "_mem_wdata"}, 64'(s_mem_wdata), 64'(0));
        chk({tag, "_count"}, 64'(s_count), 64'(0));
        chk({tag, "_full"}, 64'(s_full), 64'(0));
        chk({tag, "_err"}, 64'(s_err), 64'(0));
    endtask

    initial begin
        bit acc;
        int c0;
        logic [31:0] snap_d;
        logic [7:0]  snap_a;
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; mem_ready = 1'b1; use_b = 1'b0;
        set_cmd(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 26'd0);

        // Reset values, IDLE refuses commands.
        repeat (2) cyc(acc);
        reset = 1'b0;
        check_rst("reset");
        send(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 26'd0, 2, acc);
        chk("idle_no_accept", 64'(acc), 64'(0));
        clear_sb();

        // First word: one-cycle latency, count after the write.
        do_start();
        send_ok("add_acc", 5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 26'd0);
        chk("lat_mem_we", 64'(a_mem_we), 64'(1));
        chk("lat_addr", 64'(a_mem_addr), 64'(0));
        chk("lat_data", 64'(a_mem_wdata), 64'(32'h00221820));
        cyc(acc);
        chk("count_1", 64'(a_count), 64'(1));

        // Back-to-back I/J stream at full throughput.
        c0 = n_cyc;
        send_ok("addi_acc", 5'd8, 5'd0, 5'd4, 5'd0, 5'd0, 26'h0005);
        send_ok("beq_acc", 5'd14, 5'd4, 5'd0, 5'd0, 5'd0, 26'h0FFFF);
        send_ok("jal_acc", 5'd17, 5'd0, 5'd0, 5'd0, 5'd0, 26'h0000040);
        chk("throughput", 64'(n_cyc - c0), 64'(3));
        drain();
        chk("count_4", 64'(a_count), 64'(pushed));

        // Backpressure: outputs held, no loss or duplication.
        mem_ready = 1'b0;
        send_ok("lw_acc", 5'd12, 5'd3, 5'd9, 5'd0, 5'd0, 26'h0010);
        snap_d = a_mem_wdata;
        snap_a = a_mem_addr;
        set_cmd(5'd13, 5'd2, 5'd8, 5'd0, 5'd0, 26'h0024);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(acc);
            chk("stall_no_acc", 64'(acc), 64'(0));
            chk("stall_we", 64'(a_mem_we), 64'(1));
            chk("stall_addr", 64'(a_mem_addr), 64'(snap_a));
            chk("stall_data", 64'(a_mem_wdata), 64'(snap_d));
        end
        mem_ready = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 4 && !acc; i++) cyc(acc);
        chk("resume_acc", 64'(acc), 64'(1));
        in_valid = 1'b0;
        drain();
        chk("count_stall", 64'(a_count), 64'(pushed));

        // Illegal mnemonic: dropped, err sticky, next command still written.
        send_ok("illegal_acc", 5'd20, 5'd1, 5'd1, 5'd1, 5'd0, 26'd0);
        chk("illegal_err", 64'(a_err), 64'(exp_err));
        chk("illegal_no_we", 64'(a_mem_we), 64'(0));
        chk("illegal_count", 64'(a_count), 64'(pushed));
        send_ok("ori_acc", 5'd10, 5'd5, 5'd6, 5'd0, 5'd0, 26'h1234);
        drain();
        chk("err_sticky", 64'(a_err), 64'(1));
        chk("count_after_illegal", 64'(a_count), 64'(pushed));

        // Unused fields: flagged or masked depending on build.
        do_start();
        chk("start_clears_err", 64'(a_err), 64'(0));
        send_ok("sll_acc", 5'd5, 5'd7, 5'd2, 5'd3, 5'd4, 26'd0);
        send_ok("sub_acc", 5'd1, 5'd5, 5'd6, 5'd7, 5'd3, 26'd0);
        send_ok("jr_acc", 5'd7, 5'd31, 5'd1, 5'd0, 5'd0, 26'd0);
        send_ok("j_acc", 5'd16, 5'd0, 5'd0, 5'd0, 5'd0, 26'h3FFFFFF);
        drain();
        chk("field_err", 64'(a_err), 64'(exp_err));
        chk("field_count", 64'(a_count), 64'(pushed));

        // Small memory: wrap from BASE=2, FULL, restart.
        use_b = 1'b1;
        do_start();
        send_ok("b_w0", 5'd9, 5'd1, 5'd2, 5'd0, 5'd0, 26'h00FF);
        send_ok("b_w1", 5'd11, 5'd3, 5'd4, 5'd0, 5'd0, 26'hA5A5);
        send_ok("b_w2", 5'd2, 5'd1, 5'd2, 5'd3, 5'd0, 26'd0);
        send_ok("b_w3", 5'd15, 5'd9, 5'd10, 5'd0, 5'd0, 26'h8000);
        chk("b_last_slot_ready", 64'(b_in_ready), 64'(0));
        cyc(acc);
        chk("b_full", 64'(b_full), 64'(1));
        chk("b_count", 64'(b_count), 64'(4));
        chk("b_full_ready", 64'(b_in_ready), 64'(0));
        send(5'd0, 5'd1, 5'd1, 5'd1, 5'd0, 26'd0, 4, acc);
        chk("b_full_stall", 64'(acc), 64'(0));
        chk("b_full_no_we", 64'(b_mem_we), 64'(0));
        chk("b_drained", 64'(sb_q.size()), 64'(0));
        do_start();
        chk("b_restart_full", 64'(b_full), 64'(0));
        chk("b_restart_count", 64'(b_count), 64'(0));
        chk("b_restart_addr", 64'(b_mem_addr), 64'(2));
        use_b = 1'b0;

        // start discards a pending write and beats a same-cycle command.
        do_start();
        mem_ready = 1'b0;
        send_ok("pend_acc", 5'd4, 5'd1, 5'd2, 5'd3, 5'd0, 26'd0);
        set_cmd(5'd3, 5'd4, 5'd5, 5'd6, 5'd0, 26'd0);
        in_valid = 1'b1;
        start = 1'b1;
        cyc(acc);
        chk("start_wins", 64'(acc), 64'(0));
        start = 1'b0;
        in_valid = 1'b0;
        clear_sb();
        chk("discard_we", 64'(a_mem_we), 64'(0));
        chk("discard_count", 64'(a_count), 64'(0));
        mem_ready = 1'b1;
        repeat (3) cyc(acc);
        chk("discard_count_later", 64'(a_count), 64'(0));

        // Reset mid-stream.
        mem_ready = 1'b0;
        send_ok("pre_reset_acc", 5'd12, 5'd1, 5'd2, 5'd0, 5'd0, 26'h0004);
        reset = 1'b1;
        cyc(acc);
        reset = 1'b0;
        clear_sb();
        check_rst("mid_reset");
        mem_ready = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
